memory_data_arbiter: RTL and testbench
======================================

# memory_data_arbiter

Arbiter and dump sequencer for the data memory (`memory_data`). It shares the single memory port between the pipeline MEM stage and the debug unit's memory-dump engine. The pipeline has priority. The dump engine walks addresses 0..SIZE_MEM_DATA-1 and hands each word to the debug UART path over a valid/ready handshake. A starvation limit guarantees dump progress while the pipeline is running.

## Interface
- BITS_SIZE, 32, data/address width
- SIZE_MEM_DATA, 16, number of memory words dumped (power of 2, ≥2)
- BITS_EXTENSION, 2, width of store-size select
- STARVE_LIMIT, 4, consecutive denied dump cycles before forced grant (≥1)

- i_clk  in  1  clock, all state on posedge
- i_reset  in  1  asynchronous, active-low reset
- i_step  in  1  pipeline step enable
- i_cpu_read / i_cpu_write  in  1  MEM-stage read/write flags
- i_cpu_address  in  BITS_SIZE  MEM-stage word address
- i_cpu_wdata  in  BITS_SIZE  MEM-stage store data
- i_cpu_ctl_select  in  BITS_EXTENSION  store size (00 word, 01 byte, 10 half)
- o_cpu_rdata  out  BITS_SIZE  read data to MEM stage
- o_cpu_stall  out  1  MEM access denied this cycle; pipeline must hold
- o_mem_address, o_mem_wdata  out  BITS_SIZE  to memory
- o_mem_read, o_mem_write, o_mem_step  out  1  to memory flags/step
- o_mem_ctl_select  out  BITS_EXTENSION  to memory
- i_mem_rdata  in  BITS_SIZE  memory read data (combinational)
- i_dump_start  in  1  start dump (level sampled in IDLE)
- o_dump_busy  out  1  dump in progress
- o_dump_done  out  1  one-cycle pulse after last word accepted
- o_dump_valid  out  1  dump word available
- i_dump_ready  in  1  consumer accepts word
- o_dump_data  out  BITS_SIZE  captured word
- o_dump_addr  out  BITS_SIZE  address of o_dump_data, zero-extended

## Operation
- cpu_req = i_step & (i_cpu_read | i_cpu_write).
- FSM states:
  - IDLE: i_dump_start=1 → READ. The address counter (clog2(SIZE_MEM_DATA) bits) is cleared.
  - READ: the dump requests memory each cycle.
  - dump_grant = ~cpu_req | (starve_cnt == STARVE_LIMIT).
  - On dump_grant, i_mem_rdata is captured into o_dump_data and the counter into o_dump_addr. o_dump_valid is set, and the state moves to HOLD.
  - HOLD: waits for i_dump_ready. On acceptance, valid clears. If counter == SIZE_MEM_DATA-1 → DONE; else counter+1 → READ.
  - DONE: o_dump_done=1 for one cycle → IDLE.
- o_dump_busy = (state != IDLE).
- Memory mux (combinational):
  - READ & dump_grant: address = counter, read=1, write=0, step=1, wdata=0, ctl=00.
  - Otherwise: pass through CPU signals, step = i_step.
- o_cpu_rdata = i_mem_rdata when CPU is not preempted, else 0.
- o_cpu_stall = READ & dump_grant & cpu_req. A stalled CPU write is not issued to memory.
- starve_cnt (clog2(STARVE_LIMIT+1) bits):
  - increments in READ when cpu_req and no grant;
  - clears on dump_grant and in every other state;
  - saturates at STARVE_LIMIT.
- i_dump_start outside IDLE is ignored. No CPU stall occurs outside READ.

## Timing
- Reset (async assert, sync release at next posedge): state IDLE, counter 0, starve_cnt 0. o_dump_valid, o_dump_done, o_dump_busy, o_dump_data and o_dump_addr are 0. The combinational outputs then follow the IDLE pass-through.
- Reset mid-dump aborts immediately. No done pulse is produced, and memory is unaffected.
- Unblocked read latency: start at edge N → READ; data captured at edge N+1; o_dump_valid high from N+1.
- Handshake: a word transfers on a posedge with o_dump_valid & i_dump_ready. Data and address stay stable while valid and not ready.
- Minimum per-word cycle: 2 clocks (READ, HOLD with ready=1). A full dump takes 2·SIZE_MEM_DATA + 1 cycles including DONE.
- Worst case under continuous cpu_req: STARVE_LIMIT denied cycles, then a forced grant with o_cpu_stall=1 for exactly one cycle.
- CPU writes land on the memory's negedge in the same cycle they are passed through. A dump read of the same address in a later cycle sees the new value.

## Test plan
- memory_data preloaded with word i = i, i_step=0, start pulse, ready=1 → 16 transfers, addr/data 0..15, o_dump_done pulse at cycle 33, busy falls with it.
- Ready held low 5 cycles on word 3 → valid stays 1, data=3, addr=3 stable; transfers on the first ready cycle; no skipped or duplicated word.
- i_step=1, i_cpu_read=1 continuously during dump, STARVE_LIMIT=4 → each word granted after 4 denied cycles; o_cpu_stall high exactly 1 cycle per word; o_cpu_rdata correct on all non-stall cycles.
- CPU store word 0xDEADBEEF to address 7 while dump is at address 2 → dumped word 7 = 0xDEADBEEF. Repeat with ctl=01 → 0x000000EF.
- Assert i_reset low while in HOLD at word 9 → all dump outputs 0 asynchronously, state IDLE. A new start dumps from address 0.
- i_dump_start pulsed while busy → ignored; exactly 16 words and one done pulse.

Source files
------------

// File: rtl/memory_data_arbiter_if.sv
// Data-memory arbiter bus: MEM-stage port, memory port and dump stream.
// slave = arbiter side, master = environment side.
interface memory_data_arbiter_if #(
  parameter int BITS_SIZE      = 32,
  parameter int BITS_EXTENSION = 2
);
  logic                      i_step;
  logic                      i_cpu_read;
  logic                      i_cpu_write;
  logic [BITS_SIZE-1:0]      i_cpu_address;
  logic [BITS_SIZE-1:0]      i_cpu_wdata;
  logic [BITS_EXTENSION-1:0] i_cpu_ctl_select;
  logic [BITS_SIZE-1:0]      o_cpu_rdata;
  logic                      o_cpu_stall;

  logic [BITS_SIZE-1:0]      o_mem_address;
  logic [BITS_SIZE-1:0]      o_mem_wdata;
  logic                      o_mem_read;
  logic                      o_mem_write;
  logic                      o_mem_step;
  logic [BITS_EXTENSION-1:0] o_mem_ctl_select;
  logic [BITS_SIZE-1:0]      i_mem_rdata;

  logic                      i_dump_start;
  logic                      o_dump_busy;
  logic                      o_dump_done;
  logic                      o_dump_valid;
  logic                      i_dump_ready;
  logic [BITS_SIZE-1:0]      o_dump_data;
  logic [BITS_SIZE-1:0]      o_dump_addr;

  modport slave (
    input  i_step, i_cpu_read, i_cpu_write,
    input  i_cpu_address, i_cpu_wdata,
    input  i_cpu_ctl_select,
    output o_cpu_rdata, o_cpu_stall,
    output o_mem_address, o_mem_wdata,
    output o_mem_read, o_mem_write, o_mem_step,
    output o_mem_ctl_select,
    input  i_mem_rdata,
    input  i_dump_start, i_dump_ready,
    output o_dump_busy, o_dump_done,
    output o_dump_valid,
    output o_dump_data, o_dump_addr
  );

  modport master (
    output i_step, i_cpu_read, i_cpu_write,
    output i_cpu_address, i_cpu_wdata,
    output i_cpu_ctl_select,
    input  o_cpu_rdata, o_cpu_stall,
    input  o_mem_address, o_mem_wdata,
    input  o_mem_read, o_mem_write, o_mem_step,
    input  o_mem_ctl_select,
    output i_mem_rdata,
    output i_dump_start, i_dump_ready,
    input  o_dump_busy, o_dump_done,
    input  o_dump_valid,
    input  o_dump_data, o_dump_addr
  );
endinterface

// File: rtl/memory_data_arbiter.sv
// Shares the data-memory port between the MEM stage and the dump engine.
// Pipeline wins unless the dump has been starved STARVE_LIMIT cycles.
module memory_data_arbiter #(
  parameter int BITS_SIZE      = 32,
  parameter int SIZE_MEM_DATA  = 16,
  parameter int BITS_EXTENSION = 2,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  memory_data_arbiter_if.slave  bus
);
  localparam int AW = $clog2(SIZE_MEM_DATA);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);
  localparam logic [AW-1:0] LAST  = AW'(SIZE_MEM_DATA - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [AW-1:0]        cnt_q, cnt_d;
  logic [SW-1:0]        starve_q, starve_d;
  logic                 valid_q, valid_d;
  logic [BITS_SIZE-1:0] data_q, data_d;
  logic [BITS_SIZE-1:0] addr_q, addr_d;
  logic [BITS_SIZE-1:0] cnt_ext;

  logic cpu_req;
  logic dump_grant;
  logic take;

  assign cnt_ext = {{(BITS_SIZE-AW){1'b0}}, cnt_q};

  // Arbitration terms: CPU demand and whether the dump may use the port.
  always_comb begin
    cpu_req    = bus.i_step
               & (bus.i_cpu_read | bus.i_cpu_write);
    dump_grant = ~cpu_req | (starve_q == LIMIT);
    take       = (state_q == READ) & dump_grant;
  end

  // State and datapath registers.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      starve_q <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      addr_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      addr_q   <= addr_d;
    end
  end

  // Dump sequencer next-state, capture and starvation counting.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    starve_d = '0;
    valid_d  = valid_q;
    data_d   = data_q;
    addr_d   = addr_q;
    unique case (state_q)
      IDLE: begin
        if (bus.i_dump_start) begin
          state_d = READ;
          cnt_d   = '0;
        end
      end
      READ: begin
        if (dump_grant) begin
          state_d = HOLD;
          valid_d = 1'b1;
          data_d  = bus.i_mem_rdata;
          addr_d  = cnt_ext;
        end else if (starve_q != LIMIT) begin
          starve_d = starve_q + SW'(1);
        end else begin
          starve_d = starve_q;
        end
      end
      HOLD: begin
        if (bus.i_dump_ready) begin
          valid_d = 1'b0;
          if (cnt_q == LAST) begin
            state_d = DONE;
          end else begin
            cnt_d   = cnt_q + AW'(1);
            state_d = READ;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Memory port mux: a granted dump read overrides the CPU access.
  always_comb begin
    bus.o_mem_address    = bus.i_cpu_address;
    bus.o_mem_wdata      = bus.i_cpu_wdata;
    bus.o_mem_read       = bus.i_cpu_read;
    bus.o_mem_write      = bus.i_cpu_write;
    bus.o_mem_step       = bus.i_step;
    bus.o_mem_ctl_select = bus.i_cpu_ctl_select;
    if (take) begin
      bus.o_mem_address    = cnt_ext;
      bus.o_mem_wdata      = '0;
      bus.o_mem_read       = 1'b1;
      bus.o_mem_write      = 1'b0;
      bus.o_mem_step       = 1'b1;
      bus.o_mem_ctl_select = '0;
    end
  end

  // CPU-side response and dump status outputs.
  always_comb begin
    bus.o_cpu_stall  = take & cpu_req;
    bus.o_cpu_rdata  = bus.o_cpu_stall
                     ? '0 : bus.i_mem_rdata;
    bus.o_dump_busy  = (state_q != IDLE);
    bus.o_dump_done  = (state_q == DONE);
    bus.o_dump_valid = valid_q;
    bus.o_dump_data  = data_q;
    bus.o_dump_addr  = addr_q;
  end
endmodule

// File: tb/tb_memory_data_arbiter.sv
// Bench for memory_data_arbiter: bench-side memory, transaction-level
// reference model checked every cycle, plus directed literal checks.
module tb_memory_data_arbiter;
  localparam int BS = 32;
  localparam int SZ = 16;
  localparam int BE = 2;
  localparam int SL = 4;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  memory_data_arbiter_if #(.BITS_SIZE(BS), .BITS_EXTENSION(BE)) bus();

  memory_data_arbiter #(
    .BITS_SIZE(BS), .SIZE_MEM_DATA(SZ),
    .BITS_EXTENSION(BE), .STARVE_LIMIT(SL)
  ) dut (
    .i_clk(clk), .i_reset(rst_n), .bus(bus.slave)
  );

  logic [BS-1:0] mem [SZ];
  assign bus.i_mem_rdata = mem[bus.o_mem_address[AW-1:0]];

  int n_cmp = 0;
  int n_err = 0;

  // reference model: dump progress expressed as words/waits
  bit m_busy, m_hold, m_done, m_valid;
  int m_idx, m_denied;
  logic [BS-1:0] m_data, m_addr;

  int cyc = 0;
  int done_cnt, done_cyc, n_stall, low_cnt, rel_done;
  bit stored;
  logic [BE-1:0] st_ctl;
  logic [BS-1:0] xa[$];
  logic [BS-1:0] xd[$];

  task automatic chk(string name, logic [BS-1:0] act, logic [BS-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_hold = 0; m_done = 0; m_valid = 0;
    m_idx = 0; m_denied = 0; m_data = '0; m_addr = '0;
  endtask

  task automatic clr();
    done_cnt = 0; done_cyc = 0; n_stall = 0;
    low_cnt = 0; stored = 0;
    xa.delete(); xd.delete();
  endtask

  task automatic idle();
    bus.i_step = 0; bus.i_cpu_read = 0; bus.i_cpu_write = 0;
    bus.i_cpu_address = '0; bus.i_cpu_wdata = '0;
    bus.i_cpu_ctl_select = '0; bus.i_dump_start = 0;
    bus.i_dump_ready = 1;
  endtask

  task automatic preload();
    for (int i = 0; i < SZ; i++) mem[i] = BS'(i);
  endtask

  // memory write on the negedge, size-selected, zero-filled
  task automatic mem_phase();
    logic [AW-1:0] a;
    a = bus.o_mem_address[AW-1:0];
    if (bus.o_mem_step && bus.o_mem_write) begin
      case (bus.o_mem_ctl_select)
        2'b01: mem[a] = {24'h0, bus.o_mem_wdata[7:0]};
        2'b10: mem[a] = {16'h0, bus.o_mem_wdata[15:0]};
        default: mem[a] = bus.o_mem_wdata;
      endcase
    end
  endtask

  // compare every output with the model, then advance the model
  task automatic check_step();
    bit cpu_req, want, grant, stall;
    logic [BS-1:0] e_addr, e_wdata, e_rdata;
    logic [AW-1:0] ei;
    bit e_rd, e_wr, e_st;
    logic [BE-1:0] e_ctl;
    cpu_req = bus.i_step && (bus.i_cpu_read || bus.i_cpu_write);
    want = m_busy && !m_hold && !m_done;
    grant = want && (!cpu_req || m_denied >= SL);
    stall = grant && cpu_req;
    if (grant) begin
      e_addr = BS'(m_idx); e_rd = 1; e_wr = 0; e_st = 1;
      e_wdata = '0; e_ctl = '0;
    end else begin
      e_addr = bus.i_cpu_address; e_rd = bus.i_cpu_read;
      e_wr = bus.i_cpu_write; e_st = bus.i_step;
      e_wdata = bus.i_cpu_wdata; e_ctl = bus.i_cpu_ctl_select;
    end
    ei = e_addr[AW-1:0];
    e_rdata = stall ? '0 : mem[ei];
    chk("mem_address", bus.o_mem_address, e_addr);
    chk("mem_read", BS'(bus.o_mem_read), BS'(e_rd));
    chk("mem_write", BS'(bus.o_mem_write), BS'(e_wr));
    chk("mem_step", BS'(bus.o_mem_step), BS'(e_st));
    chk("mem_wdata", bus.o_mem_wdata, e_wdata);
    chk("mem_ctl", BS'(bus.o_mem_ctl_select), BS'(e_ctl));
    chk("cpu_stall", BS'(bus.o_cpu_stall), BS'(stall));
    chk("cpu_rdata", bus.o_cpu_rdata, e_rdata);
    chk("dump_busy", BS'(bus.o_dump_busy), BS'(m_busy));
    chk("dump_done", BS'(bus.o_dump_done), BS'(m_done));
    chk("dump_valid", BS'(bus.o_dump_valid), BS'(m_valid));
    chk("dump_data", bus.o_dump_data, m_data);
    chk("dump_addr", bus.o_dump_addr, m_addr);
    if (m_done) begin
      done_cnt++; done_cyc = cyc;
      m_done = 0; m_busy = 0;
    end else if (!m_busy) begin
      if (bus.i_dump_start) begin
        m_busy = 1; m_idx = 0; m_denied = 0;
      end
    end else if (!m_hold) begin
      if (grant) begin
        m_hold = 1; m_valid = 1;
        m_data = mem[m_idx]; m_addr = BS'(m_idx);
        m_denied = 0;
        if (stall) n_stall++;
      end else begin
        m_denied++;
      end
    end else if (bus.i_dump_ready) begin
      m_valid = 0; m_hold = 0;
      xa.push_back(m_addr); xd.push_back(m_data);
      if (m_idx == SZ - 1) m_done = 1;
      else m_idx++;
    end
    cyc++;
  endtask

  task automatic tick();
    #4; mem_phase();
    #3; check_step();
    @(posedge clk); #1;
  endtask

  task automatic stim(int mode, int k);
    idle();
    case (mode)
      1: if (m_hold && m_idx == 3 && low_cnt < 5) begin
           bus.i_dump_ready = 0; low_cnt++;
         end
      2: begin
           bus.i_step = 1; bus.i_cpu_read = 1;
           bus.i_cpu_address = BS'($urandom_range(0, SZ-1));
         end
      3: if (m_valid && m_addr == 2 && !stored) begin
           bus.i_step = 1; bus.i_cpu_write = 1;
           bus.i_cpu_address = 32'd7;
           bus.i_cpu_wdata = 32'hDEADBEEF;
           bus.i_cpu_ctl_select = st_ctl;
           stored = 1;
         end
      5: if (k == 4 || k == 11 || k == 20) bus.i_dump_start = 1;
      default: ;
    endcase
  endtask

  task automatic run_dump(int mode);
    int c0;
    bit fin;
    clr();
    idle(); bus.i_dump_start = 1;
    c0 = cyc;
    tick();
    fin = 0;
    for (int k = 0; k < 400 && !fin; k++) begin
      stim(mode, k);
      tick();
      if (done_cnt > 0) fin = 1;
    end
    if (!fin) begin
      n_cmp++; n_err++;
      $display("FAIL timeout mode %0d: got no done pulse, required one", mode);
    end
    rel_done = done_cyc - c0;
    idle();
    for (int k = 0; k < 3; k++) tick();
  endtask

  task automatic chk_seq(string name);
    chk({name, "_count"}, BS'(xa.size()), 32'd16);
    for (int i = 0; i < SZ && i < xa.size(); i++) begin
      chk({name, "_addr"}, xa[i], BS'(i));
    end
  endtask

  initial begin
    bit reached;
    model_reset(); clr(); idle(); preload();
    #2;
    chk("rst_busy", BS'(bus.o_dump_busy), 32'd0);
    chk("rst_valid", BS'(bus.o_dump_valid), 32'd0);
    chk("rst_done", BS'(bus.o_dump_done), 32'd0);
    chk("rst_data", bus.o_dump_data, 32'd0);
    chk("rst_addr", bus.o_dump_addr, 32'd0);
    chk("rst_stall", BS'(bus.o_cpu_stall), 32'd0);
    @(posedge clk); #6; rst_n = 1;
    @(posedge clk); #1;
    tick(); tick();

    // plain dump, ready always high
    preload(); run_dump(0);
    chk("t1_done_cycle", BS'(rel_done), 32'd33);
    chk("t1_done_pulses", BS'(done_cnt), 32'd1);
    chk_seq("t1");
    for (int i = 0; i < SZ && i < xd.size(); i++)
      chk("t1_data", xd[i], BS'(i));

    // backpressure on word 3
    run_dump(1);
    chk("t2_done_cycle", BS'(rel_done), 32'd38);
    chk_seq("t2");
    chk("t2_word3", xd.size() > 3 ? xd[3] : '1, 32'd3);

    // continuous CPU reads, forced grants
    run_dump(2);
    chk("t3_done_cycle", BS'(rel_done), 32'd97);
    chk("t3_stalls", BS'(n_stall), 32'd16);
    chk_seq("t3");

    // CPU store overtaken by later dump read
    preload(); st_ctl = 2'b00; run_dump(3);
    chk("t4_word7", xd.size() > 7 ? xd[7] : '0, 32'hDEADBEEF);
    chk("t4_word6", xd.size() > 6 ? xd[6] : '1, 32'd6);
    preload(); st_ctl = 2'b01; run_dump(3);
    chk("t4b_word7", xd.size() > 7 ? xd[7] : '0, 32'h000000EF);

    // reset while holding word 9
    preload(); clr();
    idle(); bus.i_dump_start = 1; tick();
    reached = 0;
    for (int k = 0; k < 100 && !reached; k++) begin
      if (m_hold && m_idx == 9) reached = 1;
      else begin stim(0, k); tick(); end
    end
    chk("t5_reached_w9", BS'(reached), 32'd1);
    idle(); bus.i_dump_ready = 0;
    #2; rst_n = 0;
    #1;
    chk("t5_busy", BS'(bus.o_dump_busy), 32'd0);
    chk("t5_valid", BS'(bus.o_dump_valid), 32'd0);
    chk("t5_done", BS'(bus.o_dump_done), 32'd0);
    chk("t5_data", bus.o_dump_data, 32'd0);
    chk("t5_addr", bus.o_dump_addr, 32'd0);
    #1; mem_phase();
    #1; rst_n = 1; model_reset();
    #2; check_step();
    @(posedge clk); #1;
    chk("t5_mem9", mem[9], 32'd9);
    run_dump(0);
    chk("t5_done_cycle", BS'(rel_done), 32'd33);
    chk("t5_done_pulses", BS'(done_cnt), 32'd1);
    chk_seq("t5");

    // start pulses while busy are ignored
    run_dump(5);
    chk("t6_done_pulses", BS'(done_cnt), 32'd1);
    chk("t6_count", BS'(xa.size()), 32'd16);

    // randomized traffic against the model
    clr();
    for (int k = 0; k < 3000; k++) begin
      bus.i_step = 1'($urandom_range(0, 1));
      bus.i_cpu_read = 1'($urandom_range(0, 1));
      bus.i_cpu_write = ($urandom_range(0, 3) == 0);
      bus.i_cpu_address = BS'($urandom_range(0, SZ-1));
      bus.i_cpu_wdata = $urandom;
      bus.i_cpu_ctl_select = BE'($urandom_range(0, 2));
      bus.i_dump_start = ($urandom_range(0, 15) == 0);
      bus.i_dump_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    idle();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
